// File: rtl/sound_latch_irq_if.sv
// Bus bundle between the 68000/Z80 chip-select side and the sound latch.
// master drives strobes and data; slave is the latch/IRQ block.
interface sound_latch_irq_if;
  logic       z80_cen;
  logic       sound_latch_cs;
  logic       m68k_rw;
  logic       m68k_lds_n;
  logic [7:0] m68k_dout;
  logic       z80_latch_r_cs;
  logic       z80_latch_clr_cs;
  logic       z80_rd_n;
  logic       z80_wr_n;
  logic       M1_n;
  logic       IORQ_n;
  logic [7:0] latch_dout;
  logic       z80_int_n;
  logic       latch_overflow;

  modport master (
    output z80_cen, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
    output z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, z80_wr_n, M1_n, IORQ_n,
    input  latch_dout, z80_int_n, latch_overflow
  );

  modport slave (
    input  z80_cen, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
    input  z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, z80_wr_n, M1_n, IORQ_n,
    output latch_dout, z80_int_n, latch_overflow
  );
endinterface

// File: rtl/sound_latch_irq.sv
// 68000-to-Z80 sound command latch plus periodic Z80 interrupt timer.
// Define SOUND_LATCH_FIFO_EN to turn the single latch into a FIFO_DEPTH-byte FIFO.
module sound_latch_irq #(
  parameter int unsigned IRQ_PERIOD = 512,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk_sys,
  input logic              reset,
  sound_latch_irq_if.slave bus
);
  localparam int unsigned CntW = $clog2(IRQ_PERIOD);

  logic wq, rq, cq, ack;
  logic wq_q, rq_q, cq_q;
  logic w_edge, r_fall, c_edge;

  always_comb begin
    wq     = bus.sound_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
    rq     = bus.z80_latch_r_cs & ~bus.z80_rd_n;
    cq     = bus.z80_latch_clr_cs & ~bus.z80_wr_n;
    ack    = ~bus.M1_n & ~bus.IORQ_n;
    w_edge = wq & ~wq_q;
    r_fall = ~rq & rq_q;
    c_edge = cq & ~cq_q;
  end

  // History flops reset high so strobes held across reset release are not edges
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wq_q <= 1'b1;
      rq_q <= 1'b1;
      cq_q <= 1'b1;
    end else begin
      wq_q <= wq;
      rq_q <= rq;
      cq_q <= cq;
    end
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            int_n_q, int_n_d;
  logic            wrap;

  // A wrap beats a simultaneous acknowledge so the new interrupt is kept
  always_comb begin
    wrap    = bus.z80_cen && (cnt_q == CntW'(IRQ_PERIOD - 1));
    cnt_d   = cnt_q;
    int_n_d = int_n_q;
    if (bus.z80_cen) cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    if (wrap)     int_n_d = 1'b0;
    else if (ack) int_n_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q   <= '0;
      int_n_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      int_n_q <= int_n_d;
    end
  end

  assign bus.z80_int_n = int_n_q;

`ifdef SOUND_LATCH_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, wptr_b, rptr_q, rptr_d, rptr_b;
  logic [PtrW:0]   fcnt_q, fcnt_d, fcnt_b;
  logic [7:0]      dout_q, dout_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;

  // Clear is applied first; push and pop then act on the cleared state
  always_comb begin
    wptr_b = c_edge ? '0 : wptr_q;
    rptr_b = c_edge ? '0 : rptr_q;
    fcnt_b = c_edge ? '0 : fcnt_q;
    push   = w_edge && (fcnt_b != (PtrW + 1)'(FIFO_DEPTH));
    pop    = r_fall && (fcnt_b != '0);
    ovf_d  = ovf_q | (w_edge & ~push);
    wptr_d = push ? wptr_b + PtrW'(1) : wptr_b;
    rptr_d = pop ? rptr_b + PtrW'(1) : rptr_b;
    fcnt_d = fcnt_b + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    if (fcnt_d == '0)                       dout_d = 8'h00;
    else if (push && fcnt_d == (PtrW + 1)'(1)) dout_d = bus.m68k_dout;
    else                                    dout_d = mem_q[rptr_d];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      dout_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wptr_b] <= bus.m68k_dout;
  end

  assign bus.latch_dout     = dout_q;
  assign bus.latch_overflow = ovf_q;
`else
  logic [7:0] latch_q, latch_d;

  // Write wins over a clear in the same cycle
  always_comb begin
    latch_d = latch_q;
    if (w_edge)      latch_d = bus.m68k_dout;
    else if (c_edge) latch_d = 8'h00;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) latch_q <= 8'h00;
    else       latch_q <= latch_d;
  end

  logic unused_rd;
  assign unused_rd = r_fall ^ (FIFO_DEPTH == 0);

  assign bus.latch_dout     = latch_q;
  assign bus.latch_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_sound_latch_irq.sv
// Scoreboard bench for sound_latch_irq: expectations are queued with stimulus and
// compared after the following clock edge. Covers FIFO mode when SOUND_LATCH_FIFO_EN is set.
module tb_sound_latch_irq;
  localparam int unsigned IrqPeriod = 8;
  localparam int unsigned FifoDepth = 4;
`ifdef SOUND_LATCH_FIFO_EN
  localparam bit FifoMode = 1'b1;
`else
  localparam bit FifoMode = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  sound_latch_irq_if bus ();

  sound_latch_irq #(
    .IRQ_PERIOD(IrqPeriod),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  typedef enum logic [1:0] {SelDout, SelInt, SelOvf} sel_e;
  typedef struct {
    string      tag;
    sel_e       sel;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input sel_e sel, input logic [7:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Advance one clock, then drain the scoreboard against the post-edge outputs
  task automatic tick();
    sb_item_t it;
    @(posedge clk_sys);
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.sel)
        SelDout: check_val(it.tag, bus.latch_dout, it.exp);
        SelInt:  check_val(it.tag, {7'd0, bus.z80_int_n}, it.exp);
        default: check_val(it.tag, {7'd0, bus.latch_overflow}, it.exp);
      endcase
    end
  endtask

  task automatic wr_start(input logic [7:0] b);
    bus.sound_latch_cs = 1'b1;
    bus.m68k_rw        = 1'b0;
    bus.m68k_lds_n     = 1'b0;
    bus.m68k_dout      = b;
  endtask

  task automatic wr_end();
    bus.sound_latch_cs = 1'b0;
    bus.m68k_rw        = 1'b1;
    bus.m68k_lds_n     = 1'b1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_start(b);
    tick();
    wr_end();
    tick();
  endtask

  task automatic clr_start();
    bus.z80_latch_clr_cs = 1'b1;
    bus.z80_wr_n         = 1'b0;
  endtask

  task automatic clr_end();
    bus.z80_latch_clr_cs = 1'b0;
    bus.z80_wr_n         = 1'b1;
  endtask

  // Read cycle; exp is latch_dout one clock after the falling edge of the strobe
  task automatic rd(input string tag, input logic [7:0] exp);
    bus.z80_latch_r_cs = 1'b1;
    bus.z80_rd_n       = 1'b0;
    tick();
    bus.z80_latch_r_cs = 1'b0;
    bus.z80_rd_n       = 1'b1;
    expect_out(tag, SelDout, exp);
    tick();
  endtask

  task automatic cen_pulse(input bit chk, input string tag, input logic [7:0] exp_int);
    bus.z80_cen = 1'b1;
    if (chk) expect_out(tag, SelInt, exp_int);
    tick();
    bus.z80_cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (chk) expect_out(tag, SelInt, exp_int);
      tick();
    end
  endtask

  task automatic ack_cycle(input string tag);
    bus.M1_n   = 1'b0;
    bus.IORQ_n = 1'b0;
    expect_out(tag, SelInt, 8'd1);
    tick();
    bus.M1_n   = 1'b1;
    bus.IORQ_n = 1'b1;
    expect_out(tag, SelInt, 8'd1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset                = 1'b1;
    bus.z80_cen          = 1'b0;
    bus.sound_latch_cs   = 1'b0;
    bus.m68k_rw          = 1'b1;
    bus.m68k_lds_n       = 1'b1;
    bus.m68k_dout        = 8'h00;
    bus.z80_latch_r_cs   = 1'b0;
    bus.z80_latch_clr_cs = 1'b0;
    bus.z80_rd_n         = 1'b1;
    bus.z80_wr_n         = 1'b1;
    bus.M1_n             = 1'b1;
    bus.IORQ_n           = 1'b1;
    tick();
    expect_out("rst_dout", SelDout, 8'h00);
    expect_out("rst_int", SelInt, 8'd1);
    expect_out("rst_ovf", SelOvf, 8'd0);
    tick();
    reset = 1'b0;
    tick();

    // Held write strobe: one write only, later data changes ignored
    wr_start(8'h5A);
    expect_out("hold_first", SelDout, 8'h5A);
    tick();
    bus.m68k_dout = 8'h77;
    for (int i = 0; i < 9; i++) begin
      expect_out("hold_level", SelDout, 8'h5A);
      tick();
    end
    wr_end();
    expect_out("hold_ovf", SelOvf, 8'd0);
    tick();
    rd("hold_count", FifoMode ? 8'h00 : 8'h5A);

    // Write then clear
    wr(8'h12);
    expect_out("wr_12", SelDout, 8'h12);
    tick();
    clr_start();
    expect_out("clear", SelDout, 8'h00);
    tick();
    clr_end();
    tick();

    // Write and clear edges in the same cycle
    wr_start(8'h12);
    clr_start();
    expect_out("wr_clr_same", SelDout, 8'h12);
    tick();
    wr_end();
    clr_end();
    tick();
    rd("wr_clr_count", FifoMode ? 8'h00 : 8'h12);

    // IRQ timer
    do_reset();
    for (int i = 0; i < 7; i++) cen_pulse(1'b1, "irq_before_wrap", 8'd1);
    cen_pulse(1'b1, "irq_wrap", 8'd0);
    for (int i = 0; i < 3; i++) cen_pulse(1'b1, "irq_pending", 8'd0);
    ack_cycle("irq_ack");
    for (int i = 0; i < 4; i++) cen_pulse(1'b1, "irq_quiet", 8'd1);
    cen_pulse(1'b1, "irq_wrap2", 8'd0);
    for (int i = 0; i < 8; i++) cen_pulse(1'b1, "irq_no_queue", 8'd0);
    ack_cycle("irq_single_ack");
    for (int i = 0; i < 7; i++) cen_pulse(1'b0, "", 8'd0);
    bus.z80_cen = 1'b1;
    bus.M1_n    = 1'b0;
    bus.IORQ_n  = 1'b0;
    expect_out("wrap_and_ack", SelInt, 8'd0);
    tick();
    bus.z80_cen = 1'b0;
    bus.M1_n    = 1'b1;
    bus.IORQ_n  = 1'b1;
    expect_out("wrap_and_ack_hold", SelInt, 8'd0);
    tick();
    ack_cycle("wrap_and_ack_release");

    // Reset mid-operation with write strobe, INT low and 3 bytes queued
    for (int i = 0; i < 8; i++) cen_pulse(1'b0, "", 8'd0);
    wr(8'h3C);
    wr(8'h3D);
    wr_start(8'h3E);
    expect_out("pre_rst_int", SelInt, 8'd0);
    expect_out("pre_rst_dout", SelDout, FifoMode ? 8'h3C : 8'h3E);
    tick();
    reset = 1'b1;
    expect_out("mid_rst_dout", SelDout, 8'h00);
    expect_out("mid_rst_int", SelInt, 8'd1);
    expect_out("mid_rst_ovf", SelOvf, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("held_wq_ignored", SelDout, 8'h00);
      expect_out("held_wq_int", SelInt, 8'd1);
      tick();
    end
    wr_end();
    tick();
    rd("held_wq_no_push", 8'h00);

`ifdef SOUND_LATCH_FIFO_EN
    // Fill past depth, drain, over-read
    do_reset();
    for (int i = 1; i <= 5; i++) wr(8'(i));
    expect_out("fifo_ovf", SelOvf, 8'd1);
    expect_out("fifo_head", SelDout, 8'h01);
    tick();
    rd("fifo_pop1", 8'h02);
    rd("fifo_pop2", 8'h03);
    rd("fifo_pop3", 8'h04);
    rd("fifo_pop4", 8'h00);
    rd("fifo_pop_empty", 8'h00);

    // Simultaneous pop and push at count 2
    wr(8'hA1);
    wr(8'hA2);
    bus.z80_latch_r_cs = 1'b1;
    bus.z80_rd_n       = 1'b0;
    tick();
    bus.z80_latch_r_cs = 1'b0;
    bus.z80_rd_n       = 1'b1;
    wr_start(8'hA3);
    expect_out("fifo_pushpop", SelDout, 8'hA2);
    tick();
    wr_end();
    tick();
    rd("fifo_pp_tail", 8'hA3);
    rd("fifo_pp_count", 8'h00);
    clr_start();
    expect_out("fifo_ovf_sticky", SelOvf, 8'd1);
    tick();
    clr_end();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_latch_irq.md
Name: sound_latch_irq

Overview:
- Sits directly downstream of the chip-select decoder and bridges the 68000 main CPU to the Z80 sound CPU.
- Consumes sound_latch_cs on the 68000 side and z80_latch_r_cs / z80_latch_clr_cs on the Z80 side.
- Holds the command byte (or a small FIFO of command bytes) written by the 68000 for the Z80 to read.
- Generates the Z80's periodic maskable interrupt and clears it on the Z80 interrupt-acknowledge cycle.

Parameters:
- IRQ_PERIOD, 512, number of z80_cen pulses between periodic Z80 interrupts (≥2).
- FIFO_DEPTH, 4, latch FIFO entries; power of two; used only when SOUND_LATCH_FIFO_EN is defined.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- z80_cen  in  1  Z80 clock-enable pulse, one clk_sys wide.
- sound_latch_cs  in  1  68000 select for the sound latch.
- m68k_rw  in  1  68000 R/W; 1 = read.
- m68k_lds_n  in  1  68000 lower data strobe, active low.
- m68k_dout  in  8  68000 write data, low byte.
- z80_latch_r_cs  in  1  Z80 latch read select (IO port 0x06).
- z80_latch_clr_cs  in  1  Z80 latch clear select (IO port 0x04).
- z80_rd_n  in  1  Z80 RD, active low.
- z80_wr_n  in  1  Z80 WR, active low.
- M1_n  in  1  Z80 M1, active low.
- IORQ_n  in  1  Z80 IORQ, active low.
- latch_dout  out  8  byte presented to the Z80 data-in mux.
- z80_int_n  out  1  Z80 INT, active low.
- latch_overflow  out  1  sticky flag: a 68000 write was dropped.

Behaviour:
- Reset values: latch_dout=0x00, z80_int_n=1, latch_overflow=0, IRQ counter=0, FIFO empty.
- Strobe-history registers reset to 1, so a strobe already held through reset release is ignored.
- 68000 write strobe: wq = sound_latch_cs & !m68k_rw & !m68k_lds_n.
  - Acted on at its rising edge only, detected against a registered copy.
  - Exactly one write per bus cycle, regardless of cycle length.
- Z80 read strobe: rq = z80_latch_r_cs & !z80_rd_n.
  - Pop, where applicable, occurs on the falling edge of rq, so data stays stable for the whole read.
- Z80 clear strobe: cq = z80_latch_clr_cs & !z80_wr_n; acted on at its rising edge.
- Single-register mode (macro undefined):
  - Write edge: latch <= m68k_dout. latch_dout is registered and reflects the new value 1 clk after the edge.
  - Clear edge: latch <= 0x00.
  - Reads do not alter the latch.
  - Write and clear edges in the same clk: the write wins.
  - latch_overflow is tied to 0.
- IRQ timer:
  - The counter increments on z80_cen and wraps at IRQ_PERIOD-1 to 0.
  - On the wrap cycle, z80_int_n goes low on the next clk.
  - Acknowledge = !M1_n & !IORQ_n, sampled on clk_sys. z80_int_n returns high 1 clk after the first acknowledge sample.
  - A wrap while INT is already low keeps it low; no interrupts are queued.
  - A wrap and an acknowledge in the same clk leave INT low, so the new interrupt is not lost.
  - The counter keeps running through the pending and acknowledge states.
- Reset mid-operation (bus cycle, FIFO non-empty, INT pending) returns every register to its reset value on the next edge.

Optional Feature:
- Macro: SOUND_LATCH_FIFO_EN. When defined, the latch is a FIFO of FIFO_DEPTH bytes with a count register.
- Pointers and storage:
  - Write and read pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits.
- Write edge when not full: push.
- Write edge when full: byte dropped, latch_overflow set (sticky until reset).
- Read falling edge when not empty: pop.
- Read falling edge when empty: no-op.
- latch_dout:
  - FIFO head when not empty.
  - 0x00 when empty.
  - Updated 1 clk after a push or pop.
- Push and pop in the same clk: both occur, count unchanged.
  - When the FIFO is empty, the push occurs and the pop is ignored.
- Clear edge: FIFO emptied (pointers and count to 0); latch_overflow is unchanged.
- Clear and write in the same clk: clear first, then push; result is count=1.
- Undefined: single-register mode as described in Behaviour.

Test Plan:
- Reset, then hold wq=1 for 10 clk with m68k_dout=0x5A → latch_dout=0x5A from clk 2 on; in FIFO mode count=1, not 10.
- Write 0x12, then clear edge → latch_dout=0x00 one clk after the clear. Repeat with write and clear in the same clk → single-register 0x12; FIFO count=1 with head 0x12.
- IRQ_PERIOD=8, z80_cen every 4 clk → z80_int_n low 1 clk after the 8th pulse. Acknowledge 3 pulses later → high next clk. Withhold acknowledge across 2 wraps → one continuous low, single acknowledge releases it.
- FIFO mode, FIFO_DEPTH=4: write 0x01..0x05 → latch_overflow=1. Four read cycles return 0x01,0x02,0x03,0x04, then latch_dout=0x00; a 5th read leaves state unchanged.
- FIFO mode: read falling edge and write rising edge in the same clk with count=2 → count stays 2, head advances, new byte at tail.
- Assert reset while wq is held, INT is low and the FIFO holds 3 bytes; release reset with wq still high → all outputs at reset values, no push from the held strobe.
